zip_rr_scheduler: RTL
=====================

Name: zip_rr_scheduler

Overview:
- Packet-granular round-robin scheduler that shares one downstream 4:1 sample packer (16b I/16b Q in, 4b I/4b Q out) between NUM_CH AXI-stream sample sources.
- Grants one channel per packet, passes its samples through, and tags the packet with the channel index.
- When a packet's sample count is not a multiple of GROUP, it appends zero samples so the packer always closes a full output word on tlast.
- Sits between the per-channel sample FIFOs and the packer.

Parameters:
WIDTH, 32, sample width (16b I in [31:16], 16b Q in [15:0])
NUM_CH, 2, number of requesting channels (1..4)
GROUP, 4, samples per packed output word; power of two
CHW, 2, width of channel tag; must satisfy 2^CHW >= NUM_CH

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
ch_enable  in  NUM_CH  per-channel arbitration enable
i_tdata  in  NUM_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
i_tlast  in  NUM_CH  per-channel end of packet
i_tvalid  in  NUM_CH  per-channel valid
i_tready  out  NUM_CH  per-channel ready
o_tdata  out  WIDTH  sample to packer
o_tlast  out  1  end of packet, always on a GROUP boundary
o_tvalid  out  1  output valid
o_tready  in  1  packer ready
o_tuser  out  CHW  channel index of the current packet
busy  out  1  high in PASS or PAD state

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, grp_cnt=0, pad_cnt=0, grant=0.
  - last_grant=NUM_CH-1, so channel 0 has first priority.
  - All outputs are 0 during and after reset, until a grant is made.
- Reset asserted mid-packet aborts the packet immediately. No tlast or pad is emitted. The downstream packer must be reset alongside this block.
- Handshake: a beat transfers when valid & ready are both high in the same cycle. o_tvalid never depends on o_tready.
- IDLE state:
  - o_tvalid=0, all i_tready=0.
  - Requesters are channels with i_tvalid[c] & ch_enable[c].
  - Search order starts at last_grant+1, wrapping mod NUM_CH; the first requester wins.
  - Register grant and last_grant, then go to PASS.
  - Arbitration costs exactly one bubble cycle per packet.
  - No requester: stay in IDLE.
- PASS state:
  - o_tdata = i_tdata[grant], o_tvalid = i_tvalid[grant].
  - i_tready[grant] = o_tready (combinational); all other i_tready = 0.
  - o_tuser = grant, held for the whole packet including pad beats.
  - On each transferred beat, grp_cnt increments mod GROUP.
  - Transferred beat with i_tlast[grant]=1 and grp_cnt==GROUP-1: o_tlast=1 on that beat; grp_cnt becomes 0; go to IDLE.
  - Transferred beat with i_tlast[grant]=1 and grp_cnt<GROUP-1: o_tlast=0 on that beat; pad_cnt = GROUP-1-grp_cnt; grp_cnt becomes 0; go to PAD.
- PAD state:
  - o_tdata=0, o_tvalid=1, all i_tready=0.
  - pad_cnt decrements on each transferred beat.
  - o_tlast=1 when pad_cnt==1; that beat transfers, then go to IDLE.
  - o_tready low stalls the pad with o_tdata and o_tlast held stable.
- ch_enable is sampled only in IDLE. Deasserting a channel's enable mid-packet does not truncate the packet.
- Single requester: the same channel is re-granted every packet, with one bubble between packets.
- A GROUP-aligned packet produces zero pad beats.
- Maximum pad per packet is GROUP-1 beats.
- Counter widths: grp_cnt and pad_cnt are $clog2(GROUP)+1 bits. grant and last_grant are CHW bits.

Test Plan:
- Reset, then ch0 sends 8 samples (0x00010001..0x00080008) with tlast on #8, o_tready=1. Required: 1 bubble; 8 beats passed unchanged; o_tlast on beat 8; o_tuser=0; no pad; busy falls the cycle after beat 8.
- ch1 sends 5 samples with tlast on #5. Required: beats 1-5 passed with o_tlast=0; then 3 beats of 0x00000000 with o_tlast only on the 3rd; o_tuser=1 on all 8 beats.
- ch0 and ch1 both hold continuous 4-sample packets, both enabled. Required: grants alternate 0,1,0,1; o_tuser follows the grant; each packet preceded by exactly one idle cycle.
- ch_enable=2'b10 with both channels valid. Required: only ch1 is granted; i_tready[0] stays 0. Then clear ch_enable[1] mid-packet. Required: the ch1 packet still completes.
- Random o_tready backpressure (50%) during a 6-sample packet. Required: no beat lost or duplicated; 2 pad beats follow; o_tdata/o_tlast stable while stalled.
- Assert reset during the pad beats of a ch1 packet. Required: o_tvalid=0 immediately (asynchronous); after release, the first grant goes to ch0 if it requests.

Source files
------------

// File: rtl/zip_rr_scheduler.sv
// Packet-granular round-robin scheduler feeding one shared 4:1 sample packer; pads short packets to a GROUP boundary.
// Latency: one IDLE arbitration bubble per packet, then samples pass through combinationally (zero added latency).
// Backpressure: o_tready goes straight to the granted channel's i_tready; pad beats hold o_tdata/o_tlast stable while stalled.
//
// Ports:
//   clk, reset      - clock; asynchronous active-low reset
//   ch_enable       - per-channel arbitration enable, looked at only while IDLE
//   i_tdata/i_tlast/i_tvalid/i_tready - NUM_CH AXI-stream sample sources (channel c in i_tdata[c*WIDTH +: WIDTH])
//   o_tdata/o_tlast/o_tvalid/o_tready - stream to the packer; o_tlast always closes a GROUP-aligned word
//   o_tuser         - channel index of the packet in flight (including its pad beats)
//   busy            - high while a packet (data or pad) is in flight
module zip_rr_scheduler #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 2,
  parameter int GROUP  = 4,
  parameter int CHW    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic [NUM_CH*WIDTH-1:0] i_tdata,
  input  logic [NUM_CH-1:0]       i_tlast,
  input  logic [NUM_CH-1:0]       i_tvalid,
  output logic [NUM_CH-1:0]       i_tready,
  output logic [WIDTH-1:0]        o_tdata,
  output logic                    o_tlast,
  output logic                    o_tvalid,
  input  logic                    o_tready,
  output logic [CHW-1:0]          o_tuser,
  output logic                    busy
);

  localparam int            CW       = $clog2(GROUP) + 1;
  localparam logic [CW-1:0] GRP_LAST = CW'(GROUP - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PASS = 2'd1,
    S_PAD  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_grp_cnt;
  logic [CW-1:0]   w_grp_nxt;
  logic [CW-1:0]   r_pad_cnt;
  logic [CW-1:0]   w_pad_nxt;
  logic [CHW-1:0]  r_grant;
  logic [CHW-1:0]  w_grant_nxt;
  logic [CHW-1:0]  r_last_grant;
  logic [CHW-1:0]  w_last_nxt;

  logic [NUM_CH-1:0] w_req;
  logic              w_found;
  logic [CHW-1:0]    w_pick;

  logic [WIDTH-1:0]  w_sel_dat;
  logic              w_sel_vld;
  logic              w_sel_last;
  logic              w_xfer;

  assign w_req = i_tvalid & ch_enable;

  // Mux of the granted channel's stream signals.
  always_comb begin
    w_sel_dat  = '0;
    w_sel_vld  = 1'b0;
    w_sel_last = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_grant == CHW'(c)) begin
        w_sel_dat  = i_tdata[c*WIDTH +: WIDTH];
        w_sel_vld  = i_tvalid[c];
        w_sel_last = i_tlast[c];
      end
    end
  end

  // Round-robin pick: scan offsets 1..NUM_CH from the last grant, so the
  // last granted channel is considered only after every other channel.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last_grant;
    for (int off = 1; off <= NUM_CH; off++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!w_found && w_req[c] && (((int'(r_last_grant) + off) % NUM_CH) == c)) begin
          w_found = 1'b1;
          w_pick  = CHW'(c);
        end
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_grp_nxt   = r_grp_cnt;
    w_pad_nxt   = r_pad_cnt;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last_grant;
    o_tdata     = '0;
    o_tvalid    = 1'b0;
    o_tlast     = 1'b0;
    o_tuser     = '0;
    i_tready    = '0;
    busy        = 1'b0;
    w_xfer      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_pick;
          w_last_nxt  = w_pick;
          w_state_nxt = S_PASS;
        end
      end

      S_PASS: begin
        busy     = 1'b1;
        o_tuser  = r_grant;
        o_tdata  = w_sel_dat;
        o_tvalid = w_sel_vld;
        // tlast is driven from data-side state only, so it stays stable
        // across a stall instead of following o_tready.
        o_tlast  = w_sel_vld && w_sel_last && (r_grp_cnt == GRP_LAST);
        for (int c = 0; c < NUM_CH; c++) begin
          i_tready[c] = (r_grant == CHW'(c)) && o_tready;
        end
        w_xfer = w_sel_vld && o_tready;
        if (w_xfer) begin
          if (w_sel_last) begin
            w_grp_nxt = '0;
            if (r_grp_cnt == GRP_LAST) begin
              w_state_nxt = S_IDLE;
            end else begin
              // Beats still missing to close the current packed word.
              w_pad_nxt   = GRP_LAST - r_grp_cnt;
              w_state_nxt = S_PAD;
            end
          end else begin
            w_grp_nxt = (r_grp_cnt == GRP_LAST) ? '0 : (r_grp_cnt + CNT_ONE);
          end
        end
      end

      S_PAD: begin
        busy     = 1'b1;
        o_tuser  = r_grant;
        o_tvalid = 1'b1;
        o_tlast  = (r_pad_cnt == CNT_ONE);
        w_xfer   = o_tready;
        if (w_xfer) begin
          w_pad_nxt = r_pad_cnt - CNT_ONE;
          if (r_pad_cnt == CNT_ONE) begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_grp_cnt    <= '0;
      r_pad_cnt    <= '0;
      r_grant      <= '0;
      r_last_grant <= CHW'(NUM_CH - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_grp_cnt    <= w_grp_nxt;
      r_pad_cnt    <= w_pad_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
    end
  end

endmodule
